// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out deserializer with a one-entry output holding register
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         SI,
    input  logic                         SI_valid,
    input  logic                         Clear,
    output logic [WIDTH-1:0]             PO,
    output logic                         PO_valid,
    input  logic                         PO_ready,
    output logic [$clog2(WIDTH+1)-1:0]   Bit_count,
    output logic                         Overrun
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    hold_state_t       state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  po_q, po_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic [WIDTH-1:0]  word;
    logic              complete;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= HOLD_EMPTY;
            shift_q <= '0;
            po_q    <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        po_d     = po_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        word     = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], SI} : {SI, shift_q[WIDTH-1:1]};
        // A cleared cycle never completes a word, so Clear always beats a coincident overrun.
        complete = SI_valid && !Clear && (cnt_q == LAST);

        if (Clear) begin
            shift_d = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (SI_valid) begin
            shift_d = word;
            cnt_d   = complete ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            HOLD_EMPTY: begin
                if (complete) begin
                    po_d    = word;
                    state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (complete) begin
                    if (PO_ready) begin
                        po_d = word;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (PO_ready) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    assign PO        = po_q;
    assign PO_valid  = (state_q == HOLD_FULL);
    assign Bit_count = cnt_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - three deserializer variants on shared stimulus against a bit-list reference model
module tb_sipo_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, si, si_valid, clear, po_ready;

    logic [3:0] po_a, po_b;
    logic [7:0] po_c;
    logic       pv_a, pv_b, pv_c;
    logic [2:0] bc_a, bc_b;
    logic [3:0] bc_c;
    logic       ov_a, ov_b, ov_c;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) u_dut_a (
        .Clock(clk), .Reset_n(rst_n), .SI(si), .SI_valid(si_valid), .Clear(clear),
        .PO(po_a), .PO_valid(pv_a), .PO_ready(po_ready), .Bit_count(bc_a), .Overrun(ov_a));

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) u_dut_b (
        .Clock(clk), .Reset_n(rst_n), .SI(si), .SI_valid(si_valid), .Clear(clear),
        .PO(po_b), .PO_valid(pv_b), .PO_ready(po_ready), .Bit_count(bc_b), .Overrun(ov_b));

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) u_dut_c (
        .Clock(clk), .Reset_n(rst_n), .SI(si), .SI_valid(si_valid), .Clear(clear),
        .PO(po_c), .PO_valid(pv_c), .PO_ready(po_ready), .Bit_count(bc_c), .Overrun(ov_c));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: received bits are kept as a plain list and packed into a word by weight.
    int              m_w  [3] = '{4, 4, 8};
    bit              m_msb[3] = '{1'b1, 1'b0, 1'b1};
    bit              m_bits[3][64];
    int              m_cnt[3];
    longint unsigned m_po [3];
    bit              m_pv [3];
    bit              m_ov [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_po[i]  = 0;
            m_pv[i]  = 1'b0;
            m_ov[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit s, input bit v, input bit c, input bit r);
        for (int i = 0; i < 3; i++) begin
            bit              done;
            longint unsigned word;
            done = 1'b0;
            word = 0;
            if (c) begin
                m_cnt[i] = 0;
                m_ov[i]  = 1'b0;
            end else if (v) begin
                m_bits[i][m_cnt[i]] = s;
                if (m_cnt[i] == m_w[i] - 1) begin
                    for (int k = 0; k < m_w[i]; k++) begin
                        if (m_msb[i]) word = word + (64'(m_bits[i][k]) << (m_w[i] - 1 - k));
                        else          word = word + (64'(m_bits[i][k]) << k);
                    end
                    done     = 1'b1;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
            end
            if (done && (!m_pv[i] || r)) begin
                m_po[i] = word;
                m_pv[i] = 1'b1;
            end else if (done) begin
                m_ov[i] = 1'b1;
            end else if (m_pv[i] && r) begin
                m_pv[i] = 1'b0;
            end
        end
    endtask

    task automatic check_inst(input string name, input int i, input logic [63:0] po,
                              input logic [63:0] pv, input logic [63:0] bc, input logic [63:0] ov);
        check({name, ".PO"},        po, m_po[i]);
        check({name, ".PO_valid"},  pv, 64'(m_pv[i]));
        check({name, ".Bit_count"}, bc, 64'(m_cnt[i]));
        check({name, ".Overrun"},   ov, 64'(m_ov[i]));
    endtask

    task automatic check_all();
        check_inst("w4msb", 0, 64'(po_a), 64'(pv_a), 64'(bc_a), 64'(ov_a));
        check_inst("w4lsb", 1, 64'(po_b), 64'(pv_b), 64'(bc_b), 64'(ov_b));
        check_inst("w8msb", 2, 64'(po_c), 64'(pv_c), 64'(bc_c), 64'(ov_c));
    endtask

    task automatic step(input bit s, input bit v, input bit c, input bit r);
        si       = s;
        si_valid = v;
        clear    = c;
        po_ready = r;
        @(posedge clk);
        model_edge(s, v, c, r);
        #1;
        check_all();
    endtask

    // Called 1 time unit after an edge: reset pulses entirely between two edges.
    task automatic mid_cycle_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    task automatic sync();
        step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bit         seq[4];
        logic [7:0] a5;

        rst_n = 1'b0; si = 1'b0; si_valid = 1'b0; clear = 1'b0; po_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Basic MSB/LSB-first assembly with the consumer always ready.
        sync();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("basic.msb.PO", 64'(po_a), 64'h0B);
        check("basic.msb.PO_valid", 64'(pv_a), 64'h1);
        check("basic.msb.Bit_count", 64'(bc_a), 64'h0);
        check("basic.lsb.PO", 64'(po_b), 64'h0D);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("basic.msb.PO_valid_drop", 64'(pv_a), 64'h0);

        // Gaps in SI_valid between bits.
        sync();
        seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            step(seq[k], 1'b1, 1'b0, 1'b1);
            if (k < 3) begin
                repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
                check("gap.lsb.Bit_count", 64'(bc_b), 64'(k + 1));
            end
        end
        check("gap.lsb.PO", 64'(po_b), 64'h0D);
        check("gap.lsb.PO_valid", 64'(pv_b), 64'h1);

        // Overrun while the consumer stalls.
        sync();
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr.PO", 64'(po_a), 64'h0F);
        check("ovr.PO_valid", 64'(pv_a), 64'h1);
        check("ovr.Overrun", 64'(ov_a), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr.drain.PO_valid", 64'(pv_a), 64'h0);
        check("ovr.drain.Overrun", 64'(ov_a), 64'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr.clear.Overrun", 64'(ov_a), 64'h0);

        // Replace-on-handshake: final bit lands in the cycle the consumer takes the old word.
        sync();
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("replace.PO", 64'(po_a), 64'h05);
        check("replace.PO_valid", 64'(pv_a), 64'h1);
        check("replace.Overrun", 64'(ov_a), 64'h0);

        // Clear mid-word discards the partial word and the SI of that cycle.
        sync();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clear.Bit_count", 64'(bc_a), 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("clear.PO", 64'(po_a), 64'h06);

        // Asynchronous reset mid-word on the 8-bit variant, then a fresh word.
        sync();
        repeat (5) step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
        mid_cycle_reset();
        check("arst.PO", 64'(po_c), 64'h0);
        check("arst.Bit_count", 64'(bc_c), 64'h0);
        a5 = 8'hA5;
        for (int k = 7; k >= 0; k--) step(a5[k], 1'b1, 1'b0, 1'b1);
        check("arst.after.PO", 64'(po_c), 64'hA5);

        // Randomized traffic, including back-to-back streams and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 499) mid_cycle_reset();
            if (n >= 1200 && n < 1300)
                step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
            else
                step(1'($urandom_range(1)), ($urandom % 10) < 7,
                     ($urandom % 40) == 0, ($urandom % 10) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
